// File: rtl/bcd_time_adjuster_pkg.sv
// Shared types and helpers for the BCD time adjuster: FSM states, step
// direction and per-digit modulus.
package bcd_time_pkg;

  typedef enum logic [1:0] {IDLE, STEP, SAT, DONE} state_e;
  typedef enum logic {DIR_INC, DIR_DEC} dir_e;
  typedef logic [3:0] digit_t;

  // Odd-indexed digits are tens (modulus tens_mod), even-indexed are units.
  function automatic digit_t digit_mod(input int unsigned index,
                                       input int unsigned tens_mod);
    return index[0] ? digit_t'(tens_mod) : digit_t'(10);
  endfunction

endpackage

// File: rtl/bcd_time_adjuster_btn_repeat.sv
// One button: 2-FF synchroniser, rising-edge request and auto-repeat counter.
// Requests are only issued while the other button is released.
module btn_repeat #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  input  logic other,
  output logic level,
  output logic req
);

  localparam int unsigned CMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  logic          s1, s2, s3;
  logic          rep;
  logic [CW-1:0] cnt;

  assign level = s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      req <= 1'b0;
      rep <= 1'b0;
      cnt <= '0;
    end else begin
      s1  <= btn;
      s2  <= s1;
      s3  <= s2;
      req <= 1'b0;
      if (!s2 || other) begin
        cnt <= '0;
        rep <= 1'b0;
      end else if (!s3) begin
        req <= 1'b1;
        cnt <= CW'(1);
        rep <= 1'b0;
      end else if (cnt == CW'(rep ? REPEAT_PERIOD : REPEAT_DELAY)) begin
        // cnt holds cycles elapsed since the last issued request
        req <= 1'b1;
        cnt <= CW'(1);
        rep <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_time_adjuster.sv
// Clocked add/sub adjuster for the BCD time word: single-step and auto-repeat
// requests ripple one digit per cycle and end in a one-cycle load strobe.
module bcd_time_adjuster
  import bcd_time_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned ADJ_LSD       = 2,
  parameter int unsigned TENS_MOD      = 6,
  parameter int unsigned WRAP_MODE     = 1,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  add,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   time_in,
  output logic [4*DIGITS-1:0]   time_out,
  output logic                  load,
  output logic                  busy,
  output logic                  limit
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic add_lvl, sub_lvl, inc_req, dec_req;

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_add (
    .clk(clk), .reset_n(reset_n), .btn(add), .other(sub_lvl), .level(add_lvl), .req(inc_req)
  );

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_sub (
    .clk(clk), .reset_n(reset_n), .btn(sub), .other(add_lvl), .level(sub_lvl), .req(dec_req)
  );

  state_e              state, state_n;
  dir_e                dir, dir_n;
  logic [4*DIGITS-1:0] work, work_n, tout_n;
  logic [IW-1:0]       idx, idx_n;
  logic                flag, flag_n, load_n, limit_n, carry;
  digit_t              m, d, nd;
  int unsigned         base;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      dir      <= DIR_INC;
      work     <= '0;
      idx      <= '0;
      flag     <= 1'b0;
      time_out <= '0;
      load     <= 1'b0;
      limit    <= 1'b0;
    end else begin
      state    <= state_n;
      dir      <= dir_n;
      work     <= work_n;
      idx      <= idx_n;
      flag     <= flag_n;
      time_out <= tout_n;
      load     <= load_n;
      limit    <= limit_n;
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    dir_n   = dir;
    work_n  = work;
    idx_n   = idx;
    flag_n  = flag;
    tout_n  = time_out;
    load_n  = 1'b0;
    limit_n = 1'b0;
    carry   = 1'b0;
    base    = 32'(idx) * 4;
    m       = digit_mod(32'(idx), TENS_MOD);
    d       = work[base +: 4];
    nd      = d;

    case (state)
      IDLE: begin
        if (inc_req || dec_req) begin
          work_n  = time_in;
          idx_n   = IW'(ADJ_LSD);
          dir_n   = inc_req ? DIR_INC : DIR_DEC;
          flag_n  = 1'b0;
          state_n = STEP;
        end
      end
      STEP: begin
        if (dir == DIR_INC) begin
          if (d >= m - 1'b1) begin
            nd    = '0;
            carry = 1'b1;
          end else begin
            nd = d + 1'b1;
          end
        end else begin
          if (d == '0) begin
            nd    = m - 1'b1;
            carry = 1'b1;
          end else if (d >= m) begin
            nd = m - 1'b1;
          end else begin
            nd = d - 1'b1;
          end
        end
        work_n[base +: 4] = nd;
        if (!carry) begin
          state_n = DONE;
        end else if (32'(idx) == DIGITS - 1) begin
          flag_n  = 1'b1;
          state_n = SAT;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      SAT: begin
        if (WRAP_MODE == 0) begin
          for (int unsigned i = ADJ_LSD; i < DIGITS; i++) begin
            work_n[i*4 +: 4] = (dir == DIR_INC) ? digit_mod(i, TENS_MOD) - 1'b1 : '0;
          end
        end
        state_n = DONE;
      end
      DONE: begin
        tout_n  = work;
        load_n  = 1'b1;
        limit_n = flag;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
